// File: rtl/capi_psl_responder.sv
// PSL-side endpoint for the CAPI AFU command/buffer/response interfaces.
// Queues AFU commands and services them against an internal cacheline memory.
`timescale 1ns/1ps
module capi_psl_responder #(
  parameter int          LINES        = 64,
  parameter int          CMD_DEPTH    = 4,
  parameter int          READ_LATENCY = 1,
  parameter logic [12:0] CMD_READ     = 13'h0A00,
  parameter logic [12:0] CMD_WRITE    = 13'h0D00
) (
  input  logic         clock,
  input  logic         reset_n,
  output logic [7:0]   croom,
  input  logic         cmd_valid,
  input  logic [7:0]   cmd_tag,
  input  logic [12:0]  cmd_command,
  input  logic [63:0]  cmd_address,
  input  logic [11:0]  cmd_size,
  input  logic         cmd_parity_ok,
  output logic         bw_valid,
  output logic [7:0]   bw_tag,
  output logic [5:0]   bw_address,
  output logic [511:0] bw_data,
  output logic [7:0]   bw_parity,
  output logic         br_valid,
  output logic [7:0]   br_tag,
  output logic [5:0]   br_address,
  input  logic [511:0] br_data,
  output logic         rsp_valid,
  output logic [7:0]   rsp_tag,
  output logic [7:0]   rsp_code,
  output logic [8:0]   rsp_credits,
  output logic         overflow
);

  localparam int IW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CW = $clog2(CMD_DEPTH + 1);

  localparam logic [7:0] RSP_DONE   = 8'h00;
  localparam logic [7:0] RSP_AERROR = 8'h01;
  localparam logic [7:0] RSP_FAILED = 8'h04;

  typedef enum logic [2:0] {IDLE, RD0, RD1, WRREQ0, WRREQ1, WRWAIT, RESP} state_t;

  typedef struct packed {
    logic [7:0]  tag;
    logic [12:0] command;
    logic [63:0] address;
    logic [11:0] size;
    logic        parity_ok;
  } cmd_t;

  state_t            state;
  cmd_t              fifo [CMD_DEPTH];
  logic [1023:0]     mem  [LINES];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  cmd_t              head;
  logic              full, empty, pop, push;
  logic [7:0]        head_code;
  logic [8:0]        head_end;
  logic [7:0]        tag_q;
  logic [IW-1:0]     idx_q;
  logic [6:0]        off_q;
  logic [8:0]        end_q;
  logic              last_q;
  logic [1023:0]     wbuf;
  logic [1023:0]     wline;
  logic [1023:0]     merged;
  logic [READ_LATENCY-1:0] pv, ph;
  logic              arrive, arrive_half, mem_we;

  function automatic logic [7:0] odd_par(input logic [511:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ~^d[i*64 +: 64];
    return p;
  endfunction

  assign croom = 8'(CMD_DEPTH);

  assign head  = fifo[rd_ptr];
  assign full  = (count == CW'(CMD_DEPTH));
  assign empty = (count == '0);
  assign pop   = (state == IDLE) && !empty;
  assign push  = cmd_valid && (!full || pop);

  assign head_end = {2'b00, head.address[6:0]} + {1'b0, head.size[7:0]};

  always_comb begin
    head_code = RSP_DONE;
    if (!head.parity_ok)
      head_code = RSP_FAILED;
    else if (head.command != CMD_READ && head.command != CMD_WRITE)
      head_code = RSP_FAILED;
    else if (head.size == 12'd0 || head.size > 12'd128 ||
             (head.size & (head.size - 12'd1)) != 12'd0 ||
             (head.address[11:0] & (head.size - 12'd1)) != 12'd0)
      head_code = RSP_AERROR;
    else if (head.address[63:7] >= 57'(LINES))
      head_code = RSP_AERROR;
  end

  // Buffer-read data lands READ_LATENCY cycles after its request strobe.
  assign arrive      = pv[READ_LATENCY-1];
  assign arrive_half = ph[READ_LATENCY-1];
  assign mem_we      = (state == WRWAIT) && arrive && (arrive_half == last_q) && reset_n;

  always_comb begin
    wline = wbuf;
    if (arrive) begin
      if (arrive_half) wline[1023:512] = br_data;
      else             wline[511:0]    = br_data;
    end
    merged = mem[idx_q];
    for (int b = 0; b < 128; b++)
      if (b >= int'(off_q) && b < int'(end_q)) merged[b*8 +: 8] = wline[b*8 +: 8];
  end

  // NOTE: storage arrays carry no reset; pointers and state define validity,
  // and the backing memory must survive reset anyway.
  always_ff @(posedge clock) begin
    if (push) fifo[wr_ptr] <= '{cmd_tag, cmd_command, cmd_address, cmd_size, cmd_parity_ok};
    if (mem_we) mem[idx_q] <= merged;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      pv          <= '0;
      ph          <= '0;
      wbuf        <= '0;
      tag_q       <= '0;
      idx_q       <= '0;
      off_q       <= '0;
      end_q       <= '0;
      last_q      <= 1'b0;
      bw_valid    <= 1'b0;
      bw_tag      <= '0;
      bw_address  <= '0;
      bw_data     <= '0;
      bw_parity   <= '0;
      br_valid    <= 1'b0;
      br_tag      <= '0;
      br_address  <= '0;
      rsp_valid   <= 1'b0;
      rsp_tag     <= '0;
      rsp_code    <= '0;
      rsp_credits <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(CMD_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(CMD_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (cmd_valid && !push) overflow <= 1'b1;

      pv[0] <= br_valid;
      ph[0] <= br_address[0];
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        ph[i] <= ph[i-1];
      end
      if (arrive) begin
        if (arrive_half) wbuf[1023:512] <= br_data;
        else             wbuf[511:0]    <= br_data;
      end

      case (state)
        IDLE: if (pop) begin
          tag_q  <= head.tag;
          idx_q  <= head.address[7 +: IW];
          off_q  <= head.address[6:0];
          end_q  <= head_end;
          last_q <= (head_end > 9'd64);
          if (head_code != RSP_DONE) begin
            rsp_valid   <= 1'b1;
            rsp_tag     <= head.tag;
            rsp_code    <= head_code;
            rsp_credits <= 9'd1;
            state       <= RESP;
          end else if (head.command == CMD_READ) begin
            bw_valid   <= 1'b1;
            bw_tag     <= head.tag;
            bw_address <= 6'd0;
            bw_data    <= mem[head.address[7 +: IW]][511:0];
            bw_parity  <= odd_par(mem[head.address[7 +: IW]][511:0]);
            state      <= RD0;
          end else begin
            br_valid   <= 1'b1;
            br_tag     <= head.tag;
            br_address <= 6'd0;
            state      <= WRREQ0;
          end
        end
        RD0: begin
          bw_address <= 6'd1;
          bw_data    <= mem[idx_q][1023:512];
          bw_parity  <= odd_par(mem[idx_q][1023:512]);
          state      <= RD1;
        end
        RD1: begin
          bw_valid    <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_tag     <= tag_q;
          rsp_code    <= RSP_DONE;
          rsp_credits <= 9'd1;
          state       <= RESP;
        end
        WRREQ0: begin
          if (last_q) begin
            br_address <= 6'd1;
            state      <= WRREQ1;
          end else begin
            br_valid   <= 1'b0;
            state      <= WRWAIT;
          end
        end
        WRREQ1: begin
          br_valid <= 1'b0;
          state    <= WRWAIT;
        end
        WRWAIT: if (arrive && arrive_half == last_q) begin
          rsp_valid   <= 1'b1;
          rsp_tag     <= tag_q;
          rsp_code    <= RSP_DONE;
          rsp_credits <= 9'd1;
          state       <= RESP;
        end
        RESP: begin
          rsp_valid   <= 1'b0;
          rsp_credits <= 9'd0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capi_psl_responder.sv
// Self-checking bench for capi_psl_responder: byte-level memory model,
// response/buffer-write scoreboards and an AFU-side buffer-read data source.
`timescale 1ns/1ps
module tb_capi_psl_responder;

  localparam int          LINES = 64;
  localparam logic [12:0] RD    = 13'h0A00;
  localparam logic [12:0] WR    = 13'h0D00;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   croom;
  logic         cmd_valid = 1'b0;
  logic [7:0]   cmd_tag = '0;
  logic [12:0]  cmd_command = '0;
  logic [63:0]  cmd_address = '0;
  logic [11:0]  cmd_size = '0;
  logic         cmd_parity_ok = 1'b0;
  logic         bw_valid;
  logic [7:0]   bw_tag;
  logic [5:0]   bw_address;
  logic [511:0] bw_data;
  logic [7:0]   bw_parity;
  logic         br_valid;
  logic [7:0]   br_tag;
  logic [5:0]   br_address;
  logic [511:0] br_data = '0;
  logic         rsp_valid;
  logic [7:0]   rsp_tag;
  logic [7:0]   rsp_code;
  logic [8:0]   rsp_credits;
  logic         overflow;

  capi_psl_responder #(.LINES(LINES), .CMD_DEPTH(4), .READ_LATENCY(1),
                       .CMD_READ(RD), .CMD_WRITE(WR)) dut (
    .clock(clock), .reset_n(reset_n), .croom(croom),
    .cmd_valid(cmd_valid), .cmd_tag(cmd_tag), .cmd_command(cmd_command),
    .cmd_address(cmd_address), .cmd_size(cmd_size), .cmd_parity_ok(cmd_parity_ok),
    .bw_valid(bw_valid), .bw_tag(bw_tag), .bw_address(bw_address),
    .bw_data(bw_data), .bw_parity(bw_parity),
    .br_valid(br_valid), .br_tag(br_tag), .br_address(br_address), .br_data(br_data),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_code(rsp_code),
    .rsp_credits(rsp_credits), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] tag; logic [7:0] code; } rsp_t;
  typedef struct { logic [7:0] tag; logic [5:0] addr; logic [511:0] data; } bw_t;
  typedef struct {
    logic [7:0] tag; logic [12:0] cmd; logic [63:0] addr; logic [11:0] size;
    logic par; logic [7:0] code; int nbr; bit rnd;
  } vec_t;

  rsp_t          exp_rsp[$];
  bw_t           exp_bw[$];
  logic [7:0]    model [LINES*128];
  logic [1023:0] wline [256];
  vec_t          vecs [17];
  int            total = 0, bad = 0, cyc = 0, br_cnt = 0;
  int            rsp_cyc = 0, bw0_cyc = 0;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // AFU data source: answers each buffer-read request one cycle later.
  initial begin
    logic       pend_v;
    logic [7:0] pend_tag;
    int         pend_half;
    pend_v = 1'b0; pend_tag = '0; pend_half = 0;
    forever begin
      @(posedge clock);
      #1;
      if (pend_v) br_data = wline[pend_tag][pend_half*512 +: 512];
      else        br_data = {16{$urandom}};
      pend_v    = br_valid;
      pend_tag  = br_tag;
      pend_half = int'(br_address[0]);
    end
  end

  // Output monitor: every response and buffer-write beat is scoreboarded.
  initial begin
    logic  prev_br;
    rsp_t  r;
    bw_t   e;
    logic [7:0] p;
    prev_br = 1'b0;
    forever begin
      @(negedge clock);
      if (rsp_valid) begin
        rsp_cyc = cyc;
        check("rsp_expected", 512'(exp_rsp.size() > 0), 512'(1));
        if (exp_rsp.size() > 0) begin
          r = exp_rsp.pop_front();
          check($sformatf("rsp_tag_%0h", r.tag), 512'(rsp_tag), 512'(r.tag));
          check($sformatf("rsp_code_%0h", r.tag), 512'(rsp_code), 512'(r.code));
          check($sformatf("rsp_credits_%0h", r.tag), 512'(rsp_credits), 512'(1));
        end
      end
      if (bw_valid) begin
        if (bw_address == 6'd0) bw0_cyc = cyc;
        check("bw_expected", 512'(exp_bw.size() > 0), 512'(1));
        if (exp_bw.size() > 0) begin
          e = exp_bw.pop_front();
          for (int i = 0; i < 8; i++) p[i] = ~^e.data[i*64 +: 64];
          check($sformatf("bw_tag_%0h", e.tag), 512'(bw_tag), 512'(e.tag));
          check($sformatf("bw_addr_%0h", e.tag), 512'(bw_address), 512'(e.addr));
          check($sformatf("bw_data_%0h_%0d", e.tag, e.addr), bw_data, e.data);
          check($sformatf("bw_par_%0h", e.tag), 512'(bw_parity), 512'(p));
        end
      end
      if (br_valid) begin
        br_cnt++;
        check("br_addr", 512'(br_address), prev_br ? 512'(1) : 512'(0));
      end
      prev_br = br_valid;
    end
  end

  task automatic issue(input logic [7:0] tag, input logic [12:0] cmd, input logic [63:0] addr,
                       input logic [11:0] size, input logic par, input logic [7:0] code,
                       input bit expect_it, input bit apply);
    int   line, off;
    rsp_t r;
    bw_t  e;
    line = int'(addr[63:7]);
    off  = int'(addr[6:0]);
    cmd_valid = 1'b1; cmd_tag = tag; cmd_command = cmd;
    cmd_address = addr; cmd_size = size; cmd_parity_ok = par;
    if (expect_it) begin
      r.tag = tag; r.code = code;
      exp_rsp.push_back(r);
      if (code == 8'h00 && cmd == RD) begin
        for (int h = 0; h < 2; h++) begin
          e.tag = tag; e.addr = 6'(h);
          for (int b = 0; b < 64; b++) e.data[b*8 +: 8] = model[line*128 + h*64 + b];
          exp_bw.push_back(e);
        end
      end
    end
    if (apply && code == 8'h00 && cmd == WR)
      for (int b = 0; b < int'(size); b++)
        model[line*128 + off + b] = wline[tag][(off + b)*8 +: 8];
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_rsp.size() > 0 || exp_bw.size() > 0) && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({name, "_timeout"}, 512'(n >= 500), 512'(0));
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic rand_line(input logic [7:0] tag);
    for (int w = 0; w < 32; w++) wline[tag][w*32 +: 32] = $urandom;
  endtask

  initial begin
    int t0, b0, n;
    for (int i = 0; i < 256; i++) wline[i] = '0;
    for (int b = 0; b < 128; b++) wline[8'h10][b*8 +: 8] = 8'(b);
    wline[8'h03] = {16{64'h1122334455667788}};

    vecs[0]  = '{8'h03, WR,       64'h120,  12'd8,   1'b1, 8'h00, 1, 1'b0};
    vecs[1]  = '{8'h04, WR,       64'h104,  12'd8,   1'b1, 8'h01, 0, 1'b1};
    vecs[2]  = '{8'h05, WR,       64'h2000, 12'd8,   1'b1, 8'h01, 0, 1'b1};
    vecs[3]  = '{8'h06, RD,       64'h100,  12'd128, 1'b0, 8'h04, 0, 1'b0};
    vecs[4]  = '{8'h07, 13'h0123, 64'h100,  12'd128, 1'b1, 8'h04, 0, 1'b0};
    vecs[5]  = '{8'h08, WR,       64'h100,  12'd0,   1'b1, 8'h01, 0, 1'b1};
    vecs[6]  = '{8'h09, WR,       64'h100,  12'd129, 1'b1, 8'h01, 0, 1'b1};
    vecs[7]  = '{8'h0A, WR,       64'h100,  12'd24,  1'b1, 8'h01, 0, 1'b1};
    vecs[8]  = '{8'h0B, WR,       64'h1F0,  12'd16,  1'b1, 8'h00, 2, 1'b1};
    vecs[9]  = '{8'h0C, WR,       64'h13C,  12'd4,   1'b1, 8'h00, 1, 1'b1};
    vecs[10] = '{8'h0D, WR,       64'h140,  12'd64,  1'b1, 8'h00, 2, 1'b1};
    vecs[11] = '{8'h0E, WR,       64'h180,  12'd128, 1'b1, 8'h00, 2, 1'b1};
    vecs[12] = '{8'h0F, RD,       64'h100,  12'd128, 1'b1, 8'h00, 0, 1'b0};
    vecs[13] = '{8'h12, RD,       64'h1C0,  12'd64,  1'b1, 8'h00, 0, 1'b0};
    vecs[14] = '{8'h13, 13'h0001, 64'h104,  12'd8,   1'b1, 8'h04, 0, 1'b0};
    vecs[15] = '{8'h14, WR,       64'h1F80, 12'd128, 1'b1, 8'h00, 2, 1'b1};
    vecs[16] = '{8'h15, RD,       64'h1F80, 12'd128, 1'b1, 8'h00, 0, 1'b0};

    repeat (3) @(posedge clock);
    #1;
    check("rst_croom", 512'(croom), 512'(4));
    check("rst_bw_valid", 512'(bw_valid), 512'(0));
    check("rst_br_valid", 512'(br_valid), 512'(0));
    check("rst_rsp_valid", 512'(rsp_valid), 512'(0));
    check("rst_rsp_credits", 512'(rsp_credits), 512'(0));
    check("rst_overflow", 512'(overflow), 512'(0));
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Preload lines 2 and 3 with full-line writes.
    rand_line(8'h11);
    b0 = br_cnt;
    issue(8'h10, WR, 64'h100, 12'd128, 1'b1, 8'h00, 1'b1, 1'b1);
    issue(8'h11, WR, 64'h180, 12'd128, 1'b1, 8'h00, 1'b1, 1'b1);
    cmd_valid = 1'b0;
    wait_idle("preload");
    check("preload_br", 512'(br_cnt - b0), 512'(4));

    // Read of the ramp line with latency checks against issue cycle.
    t0 = cyc;
    issue(8'h01, RD, 64'h100, 12'd128, 1'b1, 8'h00, 1'b1, 1'b0);
    cmd_valid = 1'b0;
    wait_idle("rd_ramp");
    check("rd_lat_bw", 512'(bw0_cyc - t0), 512'(2));
    check("rd_lat_rsp", 512'(rsp_cyc - t0), 512'(4));

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].rnd) rand_line(vecs[i].tag);
      b0 = br_cnt;
      issue(vecs[i].tag, vecs[i].cmd, vecs[i].addr, vecs[i].size, vecs[i].par,
            vecs[i].code, 1'b1, 1'b1);
      cmd_valid = 1'b0;
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_br", i), 512'(br_cnt - b0), 512'(vecs[i].nbr));
    end

    // Long write in service, five commands behind it: the fifth is dropped.
    rand_line(8'h20);
    issue(8'h20, WR, 64'h180, 12'd128, 1'b1, 8'h00, 1'b1, 1'b1);
    for (int i = 1; i <= 5; i++)
      issue(8'(8'h20 + i), RD, 64'h180, 12'd128, 1'b1, 8'h00, i < 5, 1'b0);
    cmd_valid = 1'b0;
    wait_idle("ovf");
    check("ovf_set", 512'(overflow), 512'(1));

    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    check("ovf_cleared", 512'(overflow), 512'(0));

    // Enqueue while full in the same cycle as a dequeue is accepted.
    rand_line(8'h30);
    issue(8'h30, WR, 64'h180, 12'd128, 1'b1, 8'h00, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++)
      issue(8'(8'h30 + i), RD, 64'h180, 12'd128, 1'b1, 8'h00, 1'b1, 1'b0);
    cmd_valid = 1'b0;
    @(posedge clock);
    #1;
    issue(8'h35, RD, 64'h100, 12'd128, 1'b1, 8'h00, 1'b1, 1'b0);
    cmd_valid = 1'b0;
    wait_idle("full_pop");
    check("full_pop_no_ovf", 512'(overflow), 512'(0));

    // Reset during WRWAIT abandons the write: no response, memory untouched.
    rand_line(8'h40);
    b0 = br_cnt;
    issue(8'h40, WR, 64'h100, 12'd8, 1'b1, 8'h00, 1'b0, 1'b0);
    cmd_valid = 1'b0;
    n = 0;
    while (!br_valid && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("abandon_br_seen", 512'(br_valid), 512'(1));
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    check("abandon_rsp_valid", 512'(rsp_valid), 512'(0));
    check("abandon_br_valid", 512'(br_valid), 512'(0));
    check("abandon_br_cnt", 512'(br_cnt - b0), 512'(1));
    repeat (4) @(posedge clock);
    #1;
    issue(8'h41, RD, 64'h100, 12'd128, 1'b1, 8'h00, 1'b1, 1'b0);
    cmd_valid = 1'b0;
    wait_idle("after_abandon");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capi_psl_responder.md
Name: capi_psl_responder

Overview:
- PSL-side responder for the CAPI AFU command/buffer/response interfaces: the endpoint that accepts AFU commands and services them.
- Queues AFU commands and services reads by pushing cacheline data through buffer-write cycles.
- Services writes by pulling AFU data through buffer-read cycles with fixed read latency.
- Returns one response per command. Backed by an internal cacheline memory; used as the host-side endpoint in work-element benches and loopback builds.

Parameters:
- LINES, 64, number of 128-byte cachelines in the backing memory (base address 0).
- CMD_DEPTH, 4, command FIFO depth; also the advertised command room.
- READ_LATENCY, 1, cycles from br_valid to valid br_data.
- CMD_READ, 13'h0A00, read-cacheline command code (READ_CL_NA).
- CMD_WRITE, 13'h0D00, write command code (WRITE_NA).

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- croom  out  8  advertised command credits, constant CMD_DEPTH.
- cmd_valid  in  1  AFU command strobe.
- cmd_tag  in  8  command tag.
- cmd_command  in  13  command code.
- cmd_address  in  64  effective byte address.
- cmd_size  in  12  transfer size in bytes, 1..128.
- cmd_parity_ok  in  1  AND of command/address/tag odd-parity checks.
- bw_valid  out  1  buffer-write strobe (data to AFU).
- bw_tag  out  8  tag of command being serviced.
- bw_address  out  6  half-line index: 0 = bytes 0..63, 1 = bytes 64..127.
- bw_data  out  512  half-line data.
- bw_parity  out  8  odd parity per 64-bit word of bw_data.
- br_valid  out  1  buffer-read request strobe (data from AFU).
- br_tag  out  8  tag.
- br_address  out  6  half-line index.
- br_data  in  512  AFU read data, READ_LATENCY cycles after br_valid.
- rsp_valid  out  1  response strobe.
- rsp_tag  out  8  tag of completed command.
- rsp_code  out  8  8'h00 DONE, 8'h01 AERROR, 8'h04 FAILED.
- rsp_credits  out  9  credits returned, 1 per response.
- overflow  out  1  sticky: command arrived while FIFO full.

Behaviour:
- Reset (reset_n=0 at posedge): all outputs 0 except croom; FIFO emptied; FSM to IDLE; overflow cleared; memory contents retained. Reset mid-command abandons the command with no response.
- Command capture: cmd_valid enqueues {tag, command, address, size, parity_ok} the same cycle. When the FIFO is full, the command is dropped and overflow is set. Enqueue and dequeue in the same cycle at full is legal and does not overflow.
- Checks at dequeue (IDLE), in priority order:
  - parity_ok=0 → FAILED.
  - Unknown command code → FAILED.
  - size=0, size>128, size not a power of 2, or address not aligned to size → AERROR.
  - Line index address[7+:...] ≥ LINES → AERROR.
  - Any failed check goes straight to RESP; memory is untouched.
- FSM states: IDLE, RD0, RD1, WRREQ0, WRREQ1, WRWAIT, RESP.
- Read (CMD_READ):
  - IDLE→RD0→RD1→RESP, one cycle each.
  - bw_valid is high in RD0 (address 0, line bytes 0..63) and RD1 (address 1, bytes 64..127).
  - The full line is always returned regardless of size.
  - Latency: first bw_valid 1 cycle after dequeue; response 3 cycles after dequeue.
- Write (CMD_WRITE):
  - WRREQ0 issues br_valid with address 0.
  - WRREQ1 issues address 1, only if address offset within line + size > 64; otherwise WRREQ1 is skipped.
  - WRWAIT counts READ_LATENCY cycles after the last request, capturing br_data for each half on its arrival cycle.
  - Merge only the size bytes starting at the address line offset into memory. Other bytes are unchanged.
  - Then RESP.
- RESP: rsp_valid high exactly 1 cycle with rsp_credits=1, then IDLE. Back-to-back commands: the next dequeue occurs the cycle after RESP.
- Byte order: memory byte 0 maps to bw_data[0:7]; no endianness swapping.
- Exactly one response per accepted command, in FIFO order.

Test Plan:
- Reset, preload line 2 with pattern bytes 0..127; READ_CL_NA at 0x100, tag 0x01, size 128 → bw_valid at addr 0 then addr 1 with bytes 0..63 / 64..127, then rsp tag 0x01 code 0x00 credits 1.
- WRITE_NA at 0x120, size 8, tag 0x03, br_data word 0 = 0x1122334455667788 → single br_valid (addr 0), memory bytes 0x120..0x127 updated, neighbours unchanged, rsp DONE.
- WRITE_NA at 0x104, size 8 → rsp AERROR 0x01, no br_valid, memory unchanged; address 0x2000 with LINES=64 → AERROR.
- cmd_parity_ok=0 on a read → rsp FAILED 0x04, no bw_valid.
- Five back-to-back cmd_valid with no dequeue possible (first command still in service) → overflow=1; four responses in tag order.
- Assert reset_n low during WRWAIT, then a new read → no stale response; new read completes normally.
